// File: rtl/controle_rodadas_multijogador.sv
// controle_rodadas_multijogador
//
// Round controller for GeoGenius. It runs NUM_RODADAS rounds in which
// NUM_JOGADORES players answer in turn. It owns the answer timeout timer,
// the result display timer, the per-player saturating scores (with an
// optional speed bonus) and the winner/tie decision at the end of a game.
//
// Ports
//   clock, reset_n      : single clock, asynchronous active-low reset
//   iniciar             : start request (honoured in INICIAL and FIM only)
//   fez_jogada, jogada  : one-cycle answer strobe and answer code.
//                         Strobe semantics: jogada is valid only in the cycle
//                         fez_jogada=1; there is no back-pressure, and a
//                         strobe outside AGUARDA is dropped.
//   gabarito            : correct answer from the question ROM at `rodada`.
//                         Must be stable from REGISTRA through COMPARA.
//   modo_bonus          : speed bonus enable, latched in PREPARACAO
//   rodada, jogador     : current round (ROM address) and active player
//   pronto, acertou, errou, timeout, liga_led : Moore status outputs
//   scores              : player p at [p*W_SCORE +: W_SCORE]
//   vencedor, empate    : winner / tie, valid while pronto=1
//   db_estado           : state code, 4'hB for any illegal state
module controle_rodadas_multijogador #(
  parameter int NUM_JOGADORES    = 2,
  parameter int NUM_RODADAS      = 5,
  parameter int W_RESPOSTA       = 4,
  parameter int W_SCORE          = 4,
  parameter int CICLOS_TIMEOUT   = 5000,
  parameter int CICLOS_RESULTADO = 2000,
  localparam int WR = (NUM_RODADAS > 1) ? $clog2(NUM_RODADAS) : 1,
  localparam int WJ = (NUM_JOGADORES > 1) ? $clog2(NUM_JOGADORES) : 1
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              iniciar,
  input  logic                              fez_jogada,
  input  logic [W_RESPOSTA-1:0]             jogada,
  input  logic [W_RESPOSTA-1:0]             gabarito,
  input  logic                              modo_bonus,
  output logic [WR-1:0]                     rodada,
  output logic [WJ-1:0]                     jogador,
  output logic                              pronto,
  output logic                              acertou,
  output logic                              errou,
  output logic                              timeout,
  output logic                              liga_led,
  output logic [NUM_JOGADORES*W_SCORE-1:0]  scores,
  output logic [WJ-1:0]                     vencedor,
  output logic                              empate,
  output logic [3:0]                        db_estado
);

  localparam int WT  = (CICLOS_TIMEOUT > 1) ? $clog2(CICLOS_TIMEOUT) : 1;
  localparam int WRS = (CICLOS_RESULTADO > 1) ? $clog2(CICLOS_RESULTADO) : 1;

  localparam logic [WT-1:0]  TO_MAX        = WT'(CICLOS_TIMEOUT - 1);
  localparam logic [WT-1:0]  T_META        = WT'(CICLOS_TIMEOUT / 2);
  localparam logic [WRS-1:0] RES_MAX       = WRS'(CICLOS_RESULTADO - 1);
  localparam logic [WR-1:0]  ULTIMA_RODADA = WR'(NUM_RODADAS - 1);
  localparam logic [WJ-1:0]  ULTIMO_JOG    = WJ'(NUM_JOGADORES - 1);

  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARACAO = 4'h1,
    AGUARDA    = 4'h5,
    REGISTRA   = 4'h6,
    COMPARA    = 4'h7,
    PROXIMA    = 4'h8,
    CONTA      = 4'h9,
    ACERTOU    = 4'hC,
    TIMEOUT    = 4'hD,
    ERROU      = 4'hE,
    FIM        = 4'hF
  } estado_t;

  estado_t               estado_q,   estado_d;
  logic [WR-1:0]         rodada_q,   rodada_d;
  logic [WJ-1:0]         jogador_q,  jogador_d;
  logic [W_SCORE-1:0]    scores_q [NUM_JOGADORES];
  logic [W_SCORE-1:0]    scores_d [NUM_JOGADORES];
  logic [WT-1:0]         tmr_to_q,   tmr_to_d;
  logic [WRS-1:0]        tmr_res_q,  tmr_res_d;
  logic [W_RESPOSTA-1:0] jogada_q,   jogada_d;
  logic [WT-1:0]         t_q,        t_d;
  logic                  bonus_q,    bonus_d;
  logic [WJ-1:0]         vencedor_q, vencedor_d;
  logic                  empate_q,   empate_d;

  // Helper signals
  logic                  ultimo_turno;
  logic [W_SCORE-1:0]    score_atual;
  logic [W_SCORE:0]      soma;
  logic [W_SCORE-1:0]    score_novo;
  logic [W_SCORE-1:0]    max_score;
  logic [WJ-1:0]         max_idx;
  logic [2:0]            n_max;

  assign ultimo_turno = (rodada_q == ULTIMA_RODADA) && (jogador_q == ULTIMO_JOG);

  // Score of the active player, plus its saturated increment. The sum is one
  // bit wider so the carry flags saturation.
  always_comb begin
    score_atual = scores_q[0];
    for (int p = 0; p < NUM_JOGADORES; p++) begin
      if (jogador_q == WJ'(p)) score_atual = scores_q[p];
    end
    if (bonus_q && (t_q < T_META)) begin
      soma = {1'b0, score_atual} + (W_SCORE+1)'(2);
    end else begin
      soma = {1'b0, score_atual} + (W_SCORE+1)'(1);
    end
    score_novo = soma[W_SCORE] ? {W_SCORE{1'b1}} : soma[W_SCORE-1:0];
  end

  // Winner: strict '>' keeps the lowest index among equal maxima.
  always_comb begin
    max_score = scores_q[0];
    max_idx   = '0;
    for (int p = 1; p < NUM_JOGADORES; p++) begin
      if (scores_q[p] > max_score) begin
        max_score = scores_q[p];
        max_idx   = WJ'(p);
      end
    end
    n_max = '0;
    for (int p = 0; p < NUM_JOGADORES; p++) begin
      if (scores_q[p] == max_score) n_max = n_max + 3'd1;
    end
  end

  // Next-state and datapath
  always_comb begin
    estado_d   = estado_q;
    rodada_d   = rodada_q;
    jogador_d  = jogador_q;
    scores_d   = scores_q;
    tmr_to_d   = tmr_to_q;
    tmr_res_d  = tmr_res_q;
    jogada_d   = jogada_q;
    t_d        = t_q;
    bonus_d    = bonus_q;
    vencedor_d = vencedor_q;
    empate_d   = empate_q;

    case (estado_q)
      INICIAL: begin
        if (iniciar) estado_d = PREPARACAO;
      end
      PREPARACAO: begin
        for (int p = 0; p < NUM_JOGADORES; p++) scores_d[p] = '0;
        rodada_d   = '0;
        jogador_d  = '0;
        tmr_to_d   = '0;
        tmr_res_d  = '0;
        bonus_d    = modo_bonus;
        vencedor_d = '0;
        empate_d   = 1'b0;
        estado_d   = AGUARDA;
      end
      AGUARDA: begin
        // Expiry wins over a simultaneous answer; the timer holds at its
        // terminal value until PROXIMA clears it.
        if (tmr_to_q == TO_MAX) begin
          estado_d = TIMEOUT;
        end else begin
          tmr_to_d = tmr_to_q + WT'(1);
          if (fez_jogada) begin
            jogada_d = jogada;
            estado_d = REGISTRA;
          end
        end
      end
      REGISTRA: begin
        // The timer already includes the answering cycle, so t counts the
        // AGUARDA cycles up to and including the answer.
        t_d       = tmr_to_q;
        tmr_to_d  = '0;
        tmr_res_d = '0;
        estado_d  = COMPARA;
      end
      COMPARA: begin
        estado_d = (jogada_q == gabarito) ? CONTA : ERROU;
      end
      CONTA: begin
        for (int p = 0; p < NUM_JOGADORES; p++) begin
          if (jogador_q == WJ'(p)) scores_d[p] = score_novo;
        end
        estado_d = ACERTOU;
      end
      ACERTOU, TIMEOUT, ERROU: begin
        if (tmr_res_q == RES_MAX) begin
          tmr_res_d = '0;
          estado_d  = ultimo_turno ? FIM : PROXIMA;
        end else begin
          tmr_res_d = tmr_res_q + WRS'(1);
        end
      end
      PROXIMA: begin
        tmr_to_d = '0;
        if (jogador_q == ULTIMO_JOG) begin
          jogador_d = '0;
          if (rodada_q != ULTIMA_RODADA) rodada_d = rodada_q + WR'(1);
        end else begin
          jogador_d = jogador_q + WJ'(1);
        end
        estado_d = AGUARDA;
      end
      FIM: begin
        if (iniciar) estado_d = PREPARACAO;
      end
      default: estado_d = INICIAL;
    endcase

    // Winner is frozen on the way into FIM, when the scores are final.
    if ((estado_d == FIM) && (estado_q != FIM)) begin
      vencedor_d = max_idx;
      empate_d   = (n_max > 3'd1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= INICIAL;
      rodada_q   <= '0;
      jogador_q  <= '0;
      for (int p = 0; p < NUM_JOGADORES; p++) scores_q[p] <= '0;
      tmr_to_q   <= '0;
      tmr_res_q  <= '0;
      jogada_q   <= '0;
      t_q        <= '0;
      bonus_q    <= 1'b0;
      vencedor_q <= '0;
      empate_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      rodada_q   <= rodada_d;
      jogador_q  <= jogador_d;
      scores_q   <= scores_d;
      tmr_to_q   <= tmr_to_d;
      tmr_res_q  <= tmr_res_d;
      jogada_q   <= jogada_d;
      t_q        <= t_d;
      bonus_q    <= bonus_d;
      vencedor_q <= vencedor_d;
      empate_q   <= empate_d;
    end
  end

  // Moore outputs
  assign liga_led = (estado_q == AGUARDA);
  assign acertou  = (estado_q == ACERTOU);
  assign errou    = (estado_q == ERROU);
  assign timeout  = (estado_q == TIMEOUT);
  assign pronto   = (estado_q == FIM);
  assign rodada   = rodada_q;
  assign jogador  = jogador_q;
  assign vencedor = vencedor_q;
  assign empate   = empate_q;

  for (genvar g = 0; g < NUM_JOGADORES; g++) begin : g_scores
    assign scores[g*W_SCORE +: W_SCORE] = scores_q[g];
  end

  always_comb begin
    case (estado_q)
      INICIAL, PREPARACAO, AGUARDA, REGISTRA, COMPARA, PROXIMA,
      CONTA, ACERTOU, TIMEOUT, ERROU, FIM: db_estado = estado_q;
      default:                             db_estado = 4'hB;
    endcase
  end

endmodule

// File: tb/tb_controle_rodadas_multijogador.sv
`timescale 1ns/1ps
module tb_controle_rodadas_multijogador;

  localparam int NJ  = 2;
  localparam int NR  = 2;
  localparam int CT  = 8;
  localparam int CR  = 4;
  localparam int WS  = 4;
  localparam int WS2 = 2;

  // Clock / reset and shared stimulus
  logic       clock;
  logic       reset_n;
  logic       iniciar;
  logic       fez_jogada;
  logic [3:0] jogada;
  logic [3:0] gabarito;
  logic       modo_bonus;

  // Main instance (W_SCORE=4)
  logic [0:0]       rodada, jogador, vencedor;
  logic             pronto, acertou, errou, timeout, liga_led, empate;
  logic [NJ*WS-1:0] scores;
  logic [3:0]       db_estado;

  // Saturation instance (W_SCORE=2), same stimulus
  logic [0:0]        rodada_s, jogador_s, vencedor_s;
  logic              pronto_s, acertou_s, errou_s, timeout_s, liga_led_s, empate_s;
  logic [NJ*WS2-1:0] scores_s;
  logic [3:0]        db_estado_s;

  controle_rodadas_multijogador #(
    .NUM_JOGADORES(NJ), .NUM_RODADAS(NR), .W_RESPOSTA(4), .W_SCORE(WS),
    .CICLOS_TIMEOUT(CT), .CICLOS_RESULTADO(CR)
  ) dut (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .fez_jogada(fez_jogada),
    .jogada(jogada), .gabarito(gabarito), .modo_bonus(modo_bonus),
    .rodada(rodada), .jogador(jogador), .pronto(pronto), .acertou(acertou),
    .errou(errou), .timeout(timeout), .liga_led(liga_led), .scores(scores),
    .vencedor(vencedor), .empate(empate), .db_estado(db_estado)
  );

  controle_rodadas_multijogador #(
    .NUM_JOGADORES(NJ), .NUM_RODADAS(NR), .W_RESPOSTA(4), .W_SCORE(WS2),
    .CICLOS_TIMEOUT(CT), .CICLOS_RESULTADO(CR)
  ) dut_sat (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .fez_jogada(fez_jogada),
    .jogada(jogada), .gabarito(gabarito), .modo_bonus(modo_bonus),
    .rodada(rodada_s), .jogador(jogador_s), .pronto(pronto_s), .acertou(acertou_s),
    .errou(errou_s), .timeout(timeout_s), .liga_led(liga_led_s), .scores(scores_s),
    .vencedor(vencedor_s), .empate(empate_s), .db_estado(db_estado_s)
  );

  int checks;
  int failures;

  // Scoreboard entry: {state code, p1, p0 (W=4), p1, p0 (W=2)}
  logic [15:0] exp_q[$];

  // Reference model
  int m_sc[NJ];
  int m_sat[NJ];
  int mj;
  int mr;
  bit bonus_l;

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic int sat_add(input int v, input int inc, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v + inc > lim) ? lim : v + inc;
  endfunction

  function automatic logic [15:0] model_vec(input logic [3:0] st);
    return {st, 4'(m_sc[1]), 4'(m_sc[0]), 2'(m_sat[1]), 2'(m_sat[0])};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_game(input bit bonus, input bit from_fim);
    logic [3:0] idle;
    idle = from_fim ? 4'hF : 4'h0;
    checks++;
    if (db_estado !== idle)
      $display("FAIL start_idle: db_estado=%h required=%h", db_estado, idle);
    iniciar = 1'b1;
    modo_bonus = bonus;
    tick;
    iniciar = 1'b0;
    checks++;
    if (db_estado !== 4'h1) begin
      failures++;
      $display("FAIL start_prep: db_estado=%h required=1", db_estado);
    end
    tick;
    modo_bonus = ~bonus; // must already be latched
    checks++;
    if (db_estado !== 4'h5 || scores !== '0 || scores_s !== '0 || rodada !== 1'b0 || jogador !== 1'b0) begin
      failures++;
      $display("FAIL start_clear: db_estado=%h scores=%h scores_s=%h rodada=%0d jogador=%0d required 5/0/0/0/0",
               db_estado, scores, scores_s, rodada, jogador);
    end
    bonus_l = bonus;
    for (int p = 0; p < NJ; p++) begin
      m_sc[p] = 0;
      m_sat[p] = 0;
    end
    mj = 0;
    mr = 0;
  endtask

  // kind: 0 correct answer, 1 wrong answer, 2 no answer.
  // ord: AGUARDA cycle (1-based) carrying the fez_jogada pulse.
  task automatic play_turn(input int kind, input int ord);
    int n, leds, r, exp_lat, exp_leds, inc;
    bit answered, last;
    logic [3:0] exp_st, exp_after;
    logic [15:0] exp_v, got_v;

    n = 0;
    while (liga_led !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (liga_led !== 1'b1) begin
      failures++;
      $display("FAIL turn_wait_aguarda: liga_led=%b required=1 within 20 cycles", liga_led);
    end
    checks++;
    if (rodada !== 1'(mr) || jogador !== 1'(mj)) begin
      failures++;
      $display("FAIL turn_index: rodada=%0d jogador=%0d required %0d/%0d", rodada, jogador, mr, mj);
    end

    gabarito = 4'($urandom_range(0, 15));
    jogada   = (kind == 0) ? gabarito : gabarito ^ 4'($urandom_range(1, 15));
    answered = (kind != 2) && (ord < CT);
    exp_st   = !answered ? 4'hD : ((kind == 0) ? 4'hC : 4'hE);
    if (answered && kind == 0) begin
      inc = (bonus_l && ord < CT / 2) ? 2 : 1;
      m_sc[mj]  = sat_add(m_sc[mj], inc, WS);
      m_sat[mj] = sat_add(m_sat[mj], inc, WS2);
    end
    exp_q.push_back(model_vec(exp_st));
    exp_lat  = !answered ? CT : ((kind == 0) ? ord + 3 : ord + 2);
    exp_leds = answered ? ord : CT;

    n = 0;
    leds = 0;
    while (!(acertou || errou || timeout) && n < 40) begin
      if (liga_led) leds++;
      if (kind != 2 && n == ord - 1) fez_jogada = 1'b1;
      tick;
      fez_jogada = 1'b0;
      n++;
      if (answered && n == ord) begin
        checks++;
        if (db_estado !== 4'h6) begin
          failures++;
          $display("FAIL turn_registra: db_estado=%h required=6", db_estado);
        end
      end
    end
    checks++;
    if (n !== exp_lat || leds !== exp_leds) begin
      failures++;
      $display("FAIL turn_latency: cycles=%0d led_cycles=%0d required %0d/%0d", n, leds, exp_lat, exp_leds);
    end

    got_v = {db_estado, scores, scores_s};
    exp_v = exp_q.pop_front();
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL turn_result: state/scores/scores_s=%h required=%h", got_v, exp_v);
    end

    // Result display; a wrong answer also gets stray fez_jogada pulses.
    r = 0;
    while ((acertou || errou || timeout) && r < 20) begin
      if (kind == 1) begin
        fez_jogada = 1'b1;
        jogada = gabarito;
      end
      tick;
      fez_jogada = 1'b0;
      r++;
    end
    checks++;
    if (r !== CR) begin
      failures++;
      $display("FAIL result_len: cycles=%0d required=%0d", r, CR);
    end

    last = (mr == NR - 1) && (mj == NJ - 1);
    exp_after = last ? 4'hF : 4'h8;
    checks++;
    if (db_estado !== exp_after || db_estado_s !== exp_after || {scores, scores_s} !== exp_v[11:0]) begin
      failures++;
      $display("FAIL after_result: db_estado=%h db_estado_s=%h scores=%h scores_s=%h required %h/%h",
               db_estado, db_estado_s, scores, scores_s, exp_after, exp_v[11:0]);
    end
    if (!last) begin
      if (mj == NJ - 1) begin
        mj = 0;
        mr++;
      end else begin
        mj++;
      end
    end
  endtask

  task automatic check_fim(input logic [7:0] exp_scores);
    int mx, cnt;
    logic [0:0] exp_v;
    logic exp_e;
    mx = m_sc[0];
    exp_v = 1'b0;
    for (int p = 1; p < NJ; p++) begin
      if (m_sc[p] > mx) begin
        mx = m_sc[p];
        exp_v = 1'(p);
      end
    end
    cnt = 0;
    for (int p = 0; p < NJ; p++) if (m_sc[p] == mx) cnt++;
    exp_e = (cnt > 1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pronto !== 1'b1 || db_estado !== 4'hF || scores !== exp_scores || vencedor !== exp_v || empate !== exp_e) begin
        failures++;
        $display("FAIL fim: pronto=%b db_estado=%h scores=%h vencedor=%0d empate=%b required 1/F/%h/%0d/%b",
                 pronto, db_estado, scores, vencedor, empate, exp_scores, exp_v, exp_e);
      end
      tick;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) tick;
    checks++;
    if (db_estado !== 4'h0 || scores !== '0 || scores_s !== '0) begin
      failures++;
      $display("FAIL reset_state: db_estado=%h scores=%h scores_s=%h required 0/0/0", db_estado, scores, scores_s);
    end
    checks++;
    if ({pronto, acertou, errou, timeout, liga_led, rodada, jogador, vencedor, empate} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: status=%b required all zero",
               {pronto, acertou, errou, timeout, liga_led, rodada, jogador, vencedor, empate});
    end
    reset_n = 1'b1;
    repeat (2) tick;
    checks++;
    if (db_estado !== 4'h0) begin
      failures++;
      $display("FAIL idle_hold: db_estado=%h required=0", db_estado);
    end
  endtask

  task automatic test_all_correct;
    start_game(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) play_turn(0, 2);
    check_fim(8'h22);
  endtask

  task automatic test_speed_bonus;
    start_game(1'b1, 1'b1);
    play_turn(0, 1);
    play_turn(0, 5);
    play_turn(0, 2);
    play_turn(1, 3);
    check_fim(8'h14);
  endtask

  task automatic test_timeout;
    start_game(1'b1, 1'b1);
    iniciar = 1'b1; // must be ignored during play
    play_turn(2, CT);
    iniciar = 1'b0;
    play_turn(0, CT);   // answer on the expiry cycle is discarded
    play_turn(0, 4);    // t = CT/2: no bonus
    play_turn(0, 3);    // t < CT/2: bonus
    check_fim(8'h21);
  endtask

  task automatic test_saturation_restart;
    start_game(1'b1, 1'b1);
    play_turn(0, 1);
    play_turn(0, 2);
    play_turn(0, 1);
    play_turn(0, 3);
    checks++;
    if (scores_s !== 4'hF) begin
      failures++;
      $display("FAIL saturation: scores_s=%h required=F", scores_s);
    end
    check_fim(8'h44);
    start_game(1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_game;
    int n;
    n = 0;
    while (liga_led !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    gabarito = 4'($urandom_range(0, 15));
    jogada = gabarito;
    tick;
    fez_jogada = 1'b1;
    tick;
    fez_jogada = 1'b0;
    n = 0;
    while (acertou !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (acertou !== 1'b1 || scores !== 8'h01) begin
      failures++;
      $display("FAIL mid_acertou: acertou=%b scores=%h required 1/01", acertou, scores);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (db_estado !== 4'h0 || scores !== '0 || acertou !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: db_estado=%h scores=%h acertou=%b required 0/0/0", db_estado, scores, acertou);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick;
    start_game(1'b0, 1'b0);
    play_turn(0, 2);
  endtask

  // ---------------- main ----------------
  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    iniciar = 1'b0;
    fez_jogada = 1'b0;
    jogada = '0;
    gabarito = '0;
    modo_bonus = 1'b0;
    test_reset;
    test_all_correct;
    test_speed_bonus;
    test_timeout;
    test_saturation_restart;
    test_reset_mid_game;
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: entries=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
